// File: rtl/instr_encoder.sv
// Packs opcode/source/destination fields into 16-bit instruction words and
// buffers them in a first-word-fall-through queue; illegal opcodes are dropped and flagged.
module instr_encoder #(
    parameter int         DEPTH      = 4,
    parameter logic [3:0] MAX_OPCODE = 4'hB
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [3:0]               i_opcode,
    input  logic [3:0]               i_srcadd_1,
    input  logic [3:0]               i_srcadd_2,
    input  logic [3:0]               i_destadd,
    output logic [15:0]              o_instruction,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_illegal,
    output logic [15:0]              o_issued
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW:0]     DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0]     CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE = AW'(1);

    function automatic logic [15:0] pack_fields(input logic [3:0] op,
                                                input logic [3:0] s1,
                                                input logic [3:0] s2,
                                                input logic [3:0] d);
        return {op, s1, s2, d};
    endfunction

    logic [15:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          illegal_r;
    logic [15:0]   issued_r;

    logic          accept_s;
    logic          legal_s;
    logic          wr_en_s;
    logic          rd_en_s;
    logic [AW:0]   count_next_s;

    assign o_ready   = (count_r < DEPTH_L);
    assign o_valid   = (count_r != '0);
    assign o_count   = count_r;
    assign o_illegal = illegal_r;
    assign o_issued  = issued_r;

    // Handshake decode and occupancy update.
    always_comb begin
        accept_s     = i_valid && o_ready;
        legal_s      = (i_opcode <= MAX_OPCODE);
        wr_en_s      = accept_s && legal_s;
        rd_en_s      = (count_r != '0) && i_ready;
        count_next_s = count_r;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Head word is gated so the output is never X while the queue is empty.
    always_comb begin
        if (o_valid) begin
            o_instruction = mem_r[rd_ptr_r];
        end else begin
            o_instruction = 16'h0000;
        end
    end

    // Storage array; contents are intentionally not cleared by reset.
    always_ff @(posedge i_clk) begin
        if (wr_en_s && !i_reset) begin
            mem_r[wr_ptr_r] <= pack_fields(i_opcode, i_srcadd_1, i_srcadd_2, i_destadd);
        end
    end

    // Pointers, occupancy, illegal flag and issue counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            illegal_r <= 1'b0;
            issued_r  <= 16'h0000;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
                issued_r <= issued_r + 16'h0001;
            end
            count_r   <= count_next_s;
            illegal_r <= accept_s && !legal_s;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder, checked against a queue-based
// reference model of the encoder's buffering behaviour.
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        i_clk;
    logic        i_reset;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_opcode;
    logic [3:0]  i_srcadd_1;
    logic [3:0]  i_srcadd_2;
    logic [3:0]  i_destadd;
    logic [15:0] o_instruction;
    logic        o_valid;
    logic        i_ready;
    logic [2:0]  o_count;
    logic        o_illegal;
    logic [15:0] o_issued;

    int vec_cnt;
    int err_cnt;

    logic [15:0] q[$];
    logic [15:0] m_issued;
    logic        m_illegal;

    instr_encoder #(.DEPTH(DEPTH), .MAX_OPCODE(4'hB)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_opcode(i_opcode), .i_srcadd_1(i_srcadd_1), .i_srcadd_2(i_srcadd_2),
        .i_destadd(i_destadd), .o_instruction(o_instruction), .o_valid(o_valid),
        .i_ready(i_ready), .o_count(o_count), .o_illegal(o_illegal), .o_issued(o_issued)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_value("count", 32'(o_count), 32'(q.size()));
        check_value("valid", 32'(o_valid), 32'(q.size() != 0));
        check_value("ready", 32'(o_ready), 32'(q.size() < DEPTH));
        check_value("illegal", 32'(o_illegal), 32'(m_illegal));
        check_value("issued", 32'(o_issued), 32'(m_issued));
        if (q.size() != 0) begin
            check_value("instr", 32'(o_instruction), 32'(q[0]));
        end else if (^o_instruction === 1'bx) begin
            check_value("instr_x", 32'(o_instruction), 32'h0);
        end
    endtask

    // Drive one cycle, advance the model as the specification describes, then check.
    task automatic step(input logic v, input logic [3:0] op, input logic [3:0] s1,
                        input logic [3:0] s2, input logic [3:0] d,
                        input logic rdy, input logic rst);
        logic can_take;
        logic take_out;
        logic took;
        i_valid = v; i_opcode = op; i_srcadd_1 = s1; i_srcadd_2 = s2; i_destadd = d;
        i_ready = rdy; i_reset = rst;
        if (rst) begin
            q.delete();
            m_issued  = 16'h0000;
            m_illegal = 1'b0;
        end else begin
            can_take = (q.size() < DEPTH);
            take_out = (q.size() != 0) && rdy;
            took     = v && can_take;
            if (take_out) begin
                void'(q.pop_front());
                m_issued = m_issued + 16'h0001;
            end
            m_illegal = took && (op > 4'hB);
            if (took && (op <= 4'hB)) q.push_back({op, s1, s2, d});
        end
        @(posedge i_clk);
        @(negedge i_clk);
        check_all();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, rdy, 1'b0);
    endtask

    initial begin
        vec_cnt = 0; err_cnt = 0;
        q.delete(); m_issued = 16'h0000; m_illegal = 1'b0;
        i_valid = 1'b0; i_opcode = 4'h0; i_srcadd_1 = 4'h0; i_srcadd_2 = 4'h0;
        i_destadd = 4'h0; i_ready = 1'b0; i_reset = 1'b1;

        // Reset state
        step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        check_value("rst_instr", 32'(o_instruction), 32'h0000);
        check_value("rst_ready", 32'(o_ready), 32'h1);

        // Single word
        step(1'b1, 4'h2, 4'h1, 4'h3, 4'h4, 1'b0, 1'b0);
        check_value("single_instr", 32'(o_instruction), 32'h2134);
        check_value("single_count", 32'(o_count), 32'h1);
        idle(1'b1);
        check_value("single_issued", 32'(o_issued), 32'h1);

        // Fill with i_ready low: fifth tuple is held
        for (int i = 0; i < 5; i++) step(1'b1, 4'(i), 4'(i + 1), 4'(i + 2), 4'(i + 3), 1'b0, 1'b0);
        check_value("full_ready", 32'(o_ready), 32'h0);
        check_value("full_count", 32'(o_count), 32'h4);
        step(1'b1, 4'h4, 4'h5, 4'h6, 4'h7, 1'b1, 1'b0);
        check_value("full_after_deliver", 32'(o_ready), 32'h1);
        step(1'b1, 4'h4, 4'h5, 4'h6, 4'h7, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Illegal then boundary-legal opcode, and back-to-back illegals
        step(1'b1, 4'hC, 4'h1, 4'h1, 4'h1, 1'b0, 1'b0);
        check_value("illegal_pulse", 32'(o_illegal), 32'h1);
        check_value("illegal_count", 32'(o_count), 32'h0);
        step(1'b1, 4'hB, 4'h2, 4'h2, 4'h2, 1'b0, 1'b0);
        check_value("illegal_drop", 32'(o_illegal), 32'h0);
        check_value("legal_b", 32'(o_instruction), 32'hB222);
        step(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        step(1'b1, 4'hD, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        check_value("illegal_b2b", 32'(o_illegal), 32'h1);
        idle(1'b1);

        // Streaming 20 words
        for (int i = 0; i < 20; i++) step(1'b1, 4'(i % 12), 4'(i), 4'(i + 5), 4'(i + 9), 1'b1, 1'b0);
        check_value("stream_count", 32'(o_count), 32'h1);
        idle(1'b1);

        // Mid-operation reset with three words buffered
        for (int i = 0; i < 3; i++) step(1'b1, 4'h1, 4'(i), 4'h0, 4'h0, 1'b0, 1'b0);
        step(1'b1, 4'h3, 4'h3, 4'h3, 4'h3, 1'b1, 1'b1);
        check_value("mrst_count", 32'(o_count), 32'h0);
        check_value("mrst_valid", 32'(o_valid), 32'h0);
        check_value("mrst_issued", 32'(o_issued), 32'h0);
        check_value("mrst_ready", 32'(o_ready), 32'h1);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 4'($urandom),
                 4'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 99) == 0));
        end

        // Issue counter wrap: 65537 delivers after reset
        step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 65538; i++) step(1'b1, 4'h1, 4'(i), 4'(i >> 4), 4'(i >> 8), 1'b1, 1'b0);
        check_value("issued_wrap", 32'(o_issued), 32'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
